// File: rtl/int2float_pipe.sv
// int2float_pipe: two-stage streaming integer-to-float converter with valid/ready flow control.
// Define INT2FLOAT_ROUND_EN for round-to-nearest-even with saturation; otherwise the mantissa truncates.
module int2float_pipe #(
    parameter int IN_W   = 11,
    parameter int EXP_W  = 3,
    parameter int MAN_W  = 4,
    parameter int SIGNED = 0,
    localparam int OUT_W = SIGNED + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_inexact,
    output logic             out_ovf
);
    localparam int PW = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int FW = EXP_W + MAN_W;

    if ((2 ** EXP_W) - 1 < IN_W - MAN_W) begin : g_exp_chk
        $error("int2float_pipe: exponent field too narrow for IN_W - MAN_W");
    end
    if (MAN_W < 1 || MAN_W >= IN_W) begin : g_man_chk
        $error("int2float_pipe: MAN_W must satisfy 1 <= MAN_W < IN_W");
    end

`ifdef INT2FLOAT_ROUND_EN
    function automatic logic rne_inc(input logic lsb, input logic guard, input logic sticky);
        return guard & (sticky | lsb);
    endfunction

    // Returns {ovf, exp, mant}; an exponent carry past EXP_W bits pins the result at max magnitude.
    function automatic logic [FW:0] saturate(input logic [EXP_W:0] e, input logic [MAN_W-1:0] mt);
        if (e[EXP_W]) return {1'b1, {FW{1'b1}}};
        return {1'b0, e[EXP_W-1:0], mt};
    endfunction
`endif

    logic                   en;
    logic                   vld_p1, vld_p2;
    logic signed [IN_W-1:0] din_s, neg_s;
    logic                   sign_c;
    logic [IN_W-1:0]        mag_c;
    logic [PW-1:0]          lead_c;
    logic [IN_W-1:0]        mag_p1;
    logic [PW-1:0]          lead_p1;
    logic                   sign_p1;

    // A stalled output freezes the whole pipe, so one enable serves both stages.
    assign en        = ~vld_p2 | out_ready;
    assign in_ready  = en;
    assign out_valid = vld_p2;

    // Stage 1: sign/magnitude and leading-one detect
    always_comb begin
        din_s  = in_data;
        neg_s  = -din_s;
        sign_c = (SIGNED != 0) && in_data[IN_W-1];
        mag_c  = sign_c ? $unsigned(neg_s) : in_data;
        lead_c = '0;
        for (int i = 0; i < IN_W; i++)
            if (mag_c[i]) lead_c = PW'(i);
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mag_p1  <= mag_c;
            lead_p1 <= lead_c;
            sign_p1 <= sign_c;
        end
    end

    // Stage 2: align, round, saturate, pack
    int               sh;
    logic [IN_W-1:0]  sticky_mask;
    logic             guard, sticky;
    logic [EXP_W-1:0] exp_c;
    logic [MAN_W-1:0] mant_c;
    logic [FW-1:0]    fields_c;
    logic             inexact_c, ovf_c;
    logic [OUT_W-1:0] data_c;
`ifdef INT2FLOAT_ROUND_EN
    logic             inc;
    logic [MAN_W:0]   mant_x;
    logic [MAN_W-1:0] mant_r;
    logic [EXP_W:0]   exp_x;
`endif

    always_comb begin
        sh = int'(lead_p1) - MAN_W + 1;
        if (sh < 0) sh = 0;
        mant_c      = MAN_W'(mag_p1 >> sh);
        exp_c       = EXP_W'(sh);
        guard       = 1'b0;
        sticky      = 1'b0;
        sticky_mask = '0;
        if (sh > 0) begin
            guard       = |(mag_p1 & (IN_W'(1) << (sh - 1)));
            sticky_mask = (IN_W'(1) << (sh - 1)) - IN_W'(1);
            sticky      = |(mag_p1 & sticky_mask);
        end
        inexact_c = guard | sticky;
`ifdef INT2FLOAT_ROUND_EN
        inc    = rne_inc(mant_c[0], guard, sticky);
        mant_x = {1'b0, mant_c} + {{MAN_W{1'b0}}, inc};
        exp_x  = {1'b0, exp_c};
        mant_r = mant_x[MAN_W-1:0];
        if (mant_x[MAN_W]) begin
            mant_r = MAN_W'(1) << (MAN_W - 1);
            exp_x  = exp_x + (EXP_W + 1)'(1);
        end
        {ovf_c, fields_c} = saturate(exp_x, mant_r);
`else
        ovf_c    = 1'b0;
        fields_c = {exp_c, mant_c};
`endif
        data_c = OUT_W'(fields_c);
        if (SIGNED != 0) data_c[OUT_W-1] = sign_p1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            out_data    <= '0;
            out_inexact <= 1'b0;
            out_ovf     <= 1'b0;
        end else if (en) begin
            vld_p1      <= in_valid;
            vld_p2      <= vld_p1;
            out_data    <= data_c;
            out_inexact <= inexact_c;
            out_ovf     <= ovf_c;
        end
    end
endmodule

// File: tb/tb_int2float_pipe.sv
// Bench for int2float_pipe: directed vectors on an unsigned and a signed instance, reset and
// backpressure scenarios, and a random stream against a behavioural model.
module tb_int2float_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vu = 1'b0, vs = 1'b0;
    logic [10:0] du = '0, ds = '0;
    logic        ru = 1'b1, rs = 1'b1;
    logic        iru, irs, ovu, ovs, ixu, ixs, ofu, ofs;
    logic [6:0]  odu;
    logic [7:0]  ods;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    int2float_pipe #(.IN_W(11), .EXP_W(3), .MAN_W(4), .SIGNED(0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(vu), .in_ready(iru), .in_data(du),
        .out_valid(ovu), .out_ready(ru), .out_data(odu), .out_inexact(ixu), .out_ovf(ofu)
    );

    int2float_pipe #(.IN_W(11), .EXP_W(3), .MAN_W(4), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(vs), .in_ready(irs), .in_data(ds),
        .out_valid(ovs), .out_ready(rs), .out_data(ods), .out_inexact(ixs), .out_ovf(ofs)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] obs(input bit s);
        return s ? {ofs, ixs, ods} : {ofu, ixu, 1'b0, odu};
    endfunction
    function automatic logic in_rdy(input bit s);
        return s ? irs : iru;
    endfunction
    function automatic logic out_vld(input bit s);
        return s ? ovs : ovu;
    endfunction

    task automatic drive(input bit s, input logic v, input logic [10:0] d);
        if (s) begin vs = v; ds = d; end
        else begin vu = v; du = d; end
    endtask

    // Behavioural model: {ovf, inexact, sign, exp[2:0], mant[3:0]}
    function automatic logic [9:0] model(input bit s, input logic [10:0] d);
        int m, e, mant, rem;
        bit sg, inx, ovf;
        sg = s && d[10];
        m = sg ? 2048 - int'(d) : int'(d);
        e = 0;
        while ((m >> e) >= 16) e++;
        mant = m >> e;
        rem  = m - (mant << e);
        inx  = (rem != 0);
        ovf  = 1'b0;
`ifdef INT2FLOAT_ROUND_EN
        if (e > 0) begin
            if (rem > (1 << (e - 1)) || (rem == (1 << (e - 1)) && (mant % 2) == 1)) mant++;
        end
        if (mant == 16) begin mant = 8; e++; end
        if (e > 7) begin e = 7; mant = 15; ovf = 1'b1; end
`endif
        return {ovf, inx, sg, e[2:0], mant[3:0]};
    endfunction

    // One isolated beat; verifies acceptance, 2-cycle latency and the result.
    task automatic beat(input string tag, input bit s, input logic [10:0] d,
                        input logic [7:0] ed, input bit ei, input bit eo);
        logic [9:0] o;
        @(negedge clk);
        ru = 1'b1; rs = 1'b1;
        drive(s, 1'b1, d);
        #1 check_eq({tag, "_rdy"}, 32'(in_rdy(s)), 32'd1);
        @(negedge clk);
        drive(s, 1'b0, '0);
        #1 check_eq({tag, "_lat1"}, 32'(out_vld(s)), 32'd0);
        @(negedge clk);
        #1 o = obs(s);
        check_eq({tag, "_vld"}, 32'(out_vld(s)), 32'd1);
        check_eq({tag, "_data"}, 32'(o[7:0]), 32'(ed));
        check_eq({tag, "_inexact"}, 32'(o[8]), 32'(ei));
        check_eq({tag, "_ovf"}, 32'(o[9]), 32'(eo));
    endtask

    task automatic run_stream(input string tag, input bit s, input int nbeats);
        logic [9:0]  exp_q[$];
        logic [9:0]  o, e;
        logic [10:0] pd = '0;
        bit          pend = 1'b0;
        bit          rdy;
        int          sent = 0, got = 0, cyc = 0;
        while (got < nbeats && cyc < nbeats * 20) begin
            @(negedge clk);
            if (!pend && sent < nbeats && $urandom_range(99) < 80) begin
                pend = 1'b1;
                pd = ($urandom_range(3) == 0) ? 11'($urandom_range(40)) : 11'($urandom_range(2047));
            end
            rdy = ($urandom_range(99) < 70);
            if (s) rs = rdy; else ru = rdy;
            drive(s, pend, pd);
            #1;
            if (pend && in_rdy(s)) begin
                exp_q.push_back(model(s, pd));
                pend = 1'b0;
                sent++;
            end
            if (out_vld(s) && rdy) begin
                o = obs(s);
                if (exp_q.size() == 0) check_eq({tag, "_qdepth"}, 32'(exp_q.size()), 32'd1);
                else begin
                    e = exp_q.pop_front();
                    check_eq(tag, 32'(o), 32'(e));
                end
                got++;
            end
            cyc++;
        end
        check_eq({tag, "_count"}, 32'(got), 32'(nbeats));
        drive(s, 1'b0, '0);
        ru = 1'b1; rs = 1'b1;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] bp [5];
        logic [9:0]  bq[$];
        logic [9:0]  hold_exp, e;
        int          idx, got;

        #3;
        check_eq("rst_vld_u", 32'(ovu), 32'd0);
        check_eq("rst_data_u", 32'(odu), 32'd0);
        check_eq("rst_flags_u", 32'({ixu, ofu}), 32'd0);
        check_eq("rst_vld_s", 32'(ovs), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 check_eq("rst_inrdy_u", 32'(iru), 32'd1);

        beat("zero", 1'b0, 11'd0, 8'h00, 1'b0, 1'b0);
        beat("d13", 1'b0, 11'd13, 8'h0D, 1'b0, 1'b0);
        beat("d44", 1'b0, 11'd44, 8'h2B, 1'b0, 1'b0);
        beat("tie17", 1'b0, 11'd17, 8'h18, 1'b1, 1'b0);
`ifdef INT2FLOAT_ROUND_EN
        beat("tie19", 1'b0, 11'd19, 8'h1A, 1'b1, 1'b0);
        beat("max", 1'b0, 11'd2047, 8'h7F, 1'b1, 1'b1);
        beat("s_1023", 1'b1, 11'h3FF, 8'h78, 1'b1, 1'b0);
`else
        beat("tie19", 1'b0, 11'd19, 8'h19, 1'b1, 1'b0);
        beat("max", 1'b0, 11'd2047, 8'h7F, 1'b1, 1'b0);
        beat("s_1023", 1'b1, 11'h3FF, 8'h6F, 1'b1, 1'b0);
`endif
        beat("s_m1", 1'b1, 11'h7FF, 8'h81, 1'b0, 1'b0);
        beat("s_m1024", 1'b1, 11'h400, 8'hF8, 1'b0, 1'b0);
        beat("s_p5", 1'b1, 11'd5, 8'h05, 1'b0, 1'b0);

        // Reset with two beats in flight
        @(negedge clk); drive(1'b0, 1'b1, 11'd2047);
        @(negedge clk); drive(1'b0, 1'b1, 11'd19);
        @(negedge clk); drive(1'b0, 1'b0, '0);
        #1 check_eq("pre_rst_vld", 32'(ovu), 32'd1);
        check_eq("pre_rst_inexact", 32'(ixu), 32'd1);
        #1 rst = 1'b1;
        #1 check_eq("async_rst_vld", 32'(ovu), 32'd0);
        check_eq("async_rst_data", 32'(odu), 32'd0);
        check_eq("async_rst_flags", 32'({ixu, ofu}), 32'd0);
        @(negedge clk); rst = 1'b0;
        #1 check_eq("post_rst_inrdy", 32'(iru), 32'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1 check_eq("post_rst_stale", 32'(ovu), 32'd0);
        end
        beat("post_rst", 1'b0, 11'd13, 8'h0D, 1'b0, 1'b0);

        // Backpressure: six stalled cycles with the pipe full, then drain in order
        bp[0] = 11'd44; bp[1] = 11'd19; bp[2] = 11'd2047; bp[3] = 11'd13; bp[4] = 11'd300;
        hold_exp = model(1'b0, bp[0]);
        idx = 0;
        got = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            @(negedge clk);
            drive(1'b0, idx < 5, (idx < 5) ? bp[idx] : 11'd0);
            ru = (c >= 8);
            #1;
            if (c >= 2 && c < 8) begin
                check_eq("bp_inrdy", 32'(iru), 32'd0);
                check_eq("bp_vld", 32'(ovu), 32'd1);
                check_eq("bp_hold", 32'(obs(1'b0)), 32'(hold_exp));
            end
            if (vu && iru) begin
                bq.push_back(model(1'b0, bp[idx]));
                idx++;
            end
            if (ovu && ru) begin
                if (bq.size() == 0) check_eq("bp_qdepth", 32'(bq.size()), 32'd1);
                else begin
                    e = bq.pop_front();
                    check_eq("bp_order", 32'(obs(1'b0)), 32'(e));
                end
                got++;
            end
        end
        check_eq("bp_count", 32'(got), 32'd5);
        drive(1'b0, 1'b0, '0);
        ru = 1'b1;

        run_stream("rand_u", 1'b0, 10000);
        run_stream("rand_s", 1'b1, 2000);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/int2float_pipe.md
# int2float_pipe

Parametrised, pipelined integer-to-float converter: the registered, streaming successor of the combinational 11-bit int2float datapath. It accepts an unsigned or two's-complement integer per beat on a valid/ready stream and emits a packed {sign, exponent, mantissa} word two cycles later, with round-to-nearest-even, saturation and per-beat exception flags. It sits between integer producers (counters, accumulators) and low-precision float consumers.

## Interface
- IN_W, 11, input integer width (≥ 2)
- EXP_W, 3, exponent field width
- MAN_W, 4, mantissa field width, leading one explicit; 1 ≤ MAN_W < IN_W
- SIGNED, 0, 1 = input is two's complement and a sign bit is emitted
- Elaboration error unless 2^EXP_W − 1 ≥ IN_W − MAN_W
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_data  in  IN_W  integer operand
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  SIGNED+EXP_W+MAN_W  {sign (if SIGNED), exp, mant}
- out_inexact  out  1  nonzero bits were discarded
- out_ovf  out  1  rounding overflowed the exponent; result saturated

## Operation
- Format: value = mant << exp; mant is MAN_W bits; zero encodes as all-zero fields.
- Magnitude m = |in_data| (SIGNED) or in_data; sign = in_data MSB (SIGNED). −2^(IN_W−1) magnitude fits IN_W bits unsigned.
- p = index of leading one of m. If p < MAN_W: exp = 0, mant = m, exact.
- Else exp = p − MAN_W + 1, mant = m[p : p−MAN_W+1]; dropped bits m[p−MAN_W : 0] set out_inexact if nonzero.
- Rounding (see Configuration): RNE on dropped bits. If mant rounds to 2^MAN_W: mant = 2^(MAN_W−1), exp += 1. If exp then exceeds 2^EXP_W − 1: exp = all ones, mant = all ones, out_ovf = 1 (out_inexact = 1).
- Zero input: out_data = 0 (sign 0), flags 0. Sign of −0 never arises.
- Stage 1: sign/magnitude, leading-one detect, register m, p, sign. Stage 2: shift, round, saturate, pack, register outputs.
- Flow control: single enable en = ~out_valid | out_ready; in_ready = en (combinational). Both stages load on en; stage valids shift on en. Bubbles propagate; they are not collapsed.

## Timing
- Latency 2 cycles from accepted beat to out_valid; throughput 1 beat/cycle while out_ready = 1.
- While out_valid & ~out_ready: out_data, out_inexact, out_ovf, out_valid hold stable; in_ready = 0; no beat lost or duplicated.
- Ordering strictly FIFO.
- Reset (any time, including mid-stream): both stage valids, out_valid, out_data, out_inexact, out_ovf = 0; in_ready = 1 after reset. In-flight beats are dropped.
- No combinational path in_valid → out_valid; out_ready → in_ready is combinational.

## Configuration
- INT2FLOAT_ROUND_EN defined: round-to-nearest-even as above; overflow saturation and out_ovf active.
- Undefined: truncation (dropped bits discarded, mant never incremented); out_inexact still reported; out_ovf tied 0 (overflow impossible given the parameter check).

## Test plan
- Default params, ROUND_EN: in_data 0 → 0x00; 13 → 0x0D exact; 44 → 0x2B exact; inexact 0, ovf 0, each exactly 2 cycles after acceptance.
- Ties, ROUND_EN: 17 → 0x18 (stay even), 19 → 0x1A (round up), both inexact = 1; without macro 19 → 0x19.
- Overflow: 2047 → 0x7F, ovf = 1, inexact = 1; without macro 2047 → 0x7F, ovf = 0, inexact = 1.
- SIGNED = 1 (8-bit out): 0x7FF (−1) → 0x81; 0x400 (−1024) → 0xF8 exact; 0x3FF (1023) → 0x78 with ROUND_EN, inexact 1.
- Backpressure: stream 5 random beats, hold out_ready = 0 for 6 cycles; out_data stable, in_ready = 0, then all 5 results in order, none lost or repeated; compare against reference model over 10k random beats with random out_ready.
- Reset asserted with 2 beats in flight: out_valid falls asynchronously, no stale result after release, next beat emerges 2 cycles after acceptance.
